// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl : programmable divider controller (tick strobe + divided clock)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl #(
  parameter int W       = 8,
  parameter int DEF_DIV = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         tick,
  output logic         div_out,
  output logic         busy,
  output logic [W-1:0] active_div
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         r_state, w_state_nx;
  logic [W-1:0]   r_cnt, w_cnt_nx;
  logic [W-1:0]   r_act, w_act_nx;
  logic [W-1:0]   r_pend, w_pend_nx;
  logic           r_pend_v, w_pend_v_nx;
  logic           r_err, w_err_nx;

  logic           w_busy;
  logic           w_boundary;
  logic           w_xfer;
  logic           w_good;
  logic [W:0]     w_half;

  assign w_busy     = (r_state != IDLE);
  assign w_boundary = w_busy && (r_cnt == r_act - W'(1));
  assign w_xfer     = cfg_valid && !r_pend_v;
  assign w_good     = w_xfer && (cfg_div != '0);
  assign w_half     = ({1'b0, r_act} + (W+1)'(1)) >> 1;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_act_nx    = r_act;
    w_pend_nx   = r_pend;
    w_pend_v_nx = r_pend_v;
    w_err_nx    = w_xfer && (cfg_div == '0);

    case (r_state)
      IDLE:    if (enable) w_state_nx = RUN;
      RUN:     if (!enable) w_state_nx = w_boundary ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)          w_state_nx = RUN;
        else if (w_boundary) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase

    // Ratio changes only land on period edges; a ratio arriving on the edge itself bypasses pend.
    if (!w_busy) begin
      w_cnt_nx = '0;
      if (w_good) w_act_nx = cfg_div;
    end else if (w_boundary) begin
      w_cnt_nx = '0;
      if (w_good) begin
        w_act_nx = cfg_div;
      end else if (r_pend_v) begin
        w_act_nx    = r_pend;
        w_pend_v_nx = 1'b0;
      end
    end else begin
      w_cnt_nx = r_cnt + W'(1);
      if (w_good) begin
        w_pend_nx   = cfg_div;
        w_pend_v_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_act    <= W'(DEF_DIV);
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_act    <= w_act_nx;
      r_pend   <= w_pend_nx;
      r_pend_v <= w_pend_v_nx;
      r_err    <= w_err_nx;
    end
  end

  assign cfg_ready  = !r_pend_v;
  assign cfg_err    = r_err;
  assign busy       = w_busy;
  assign tick       = w_boundary;
  assign div_out    = w_busy && ({1'b0, r_cnt} < w_half);
  assign active_div = r_act;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl : vector table, directed corner cases and randomized run
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;
  localparam int W       = 8;
  localparam int DEF_DIV = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         tick;
  logic         div_out;
  logic         busy;
  logic [W-1:0] active_div;

  clk_div_ctrl #(.W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .tick       (tick),
    .div_out    (div_out),
    .busy       (busy),
    .active_div (active_div)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic         en;
    logic         v;
    logic [W-1:0] d;
    logic         t;
    logic         dv;
    logic         b;
    logic         r;
    logic         e;
    logic [W-1:0] a;
  } vec_t;

  vec_t vecs[$];

  // reference model: only "running or not", position in period, ratio, pending queue
  int m_busy, m_pos, m_n, m_err;
  int pq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input int t, input int dv, input int b,
                            input int r, input int e, input int a);
    chk({tag, ".tick"},       int'(tick),       t);
    chk({tag, ".div_out"},    int'(div_out),    dv);
    chk({tag, ".busy"},       int'(busy),       b);
    chk({tag, ".cfg_ready"},  int'(cfg_ready),  r);
    chk({tag, ".cfg_err"},    int'(cfg_err),    e);
    chk({tag, ".active_div"}, int'(active_div), a);
  endtask

  function automatic void add(input logic en, input logic v, input int d, input logic t,
                              input logic dv, input logic b, input logic r, input logic e,
                              input int a);
    vec_t x;
    x.en = en; x.v = v; x.d = W'(d);
    x.t = t; x.dv = dv; x.b = b; x.r = r; x.e = e; x.a = W'(a);
    vecs.push_back(x);
  endfunction

  // drive at the falling edge, let one rising edge pass, return at the next falling edge
  task automatic apply(input logic en, input logic v, input int d);
    enable    = en;
    cfg_valid = v;
    cfg_div   = W'(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic model_reset();
    m_busy = 0; m_pos = 0; m_n = DEF_DIV; m_err = 0;
    pq.delete();
  endtask

  task automatic model_step(input int en, input int v, input int d);
    int acc, last;
    acc   = v && (pq.size() == 0);
    last  = m_busy && (m_pos == m_n - 1);
    m_err = acc && (d == 0);
    if (!m_busy) begin
      if (acc && d != 0) m_n = d;
      if (en) begin m_busy = 1; m_pos = 0; end
    end else if (last) begin
      m_pos = 0;
      if (acc && d != 0) m_n = d;
      else if (pq.size() != 0) m_n = pq.pop_front();
      if (!en) m_busy = 0;
    end else begin
      m_pos++;
      if (acc && d != 0) pq.push_back(d);
    end
  endtask

  initial begin
    // default ratio run
    add(1, 0, 0, 0, 0, 0, 1, 0, 3);
    for (int i = 0; i < 12; i++) add(1, 0, 0, (i % 3) == 2, (i % 3) < 2, 1, 1, 0, 3);
    // reconfigure to 5 at the start of a period
    add(1, 1, 5, 0, 1, 1, 1, 0, 3);
    add(1, 0, 0, 0, 1, 1, 0, 0, 3);
    add(1, 0, 0, 1, 0, 1, 0, 0, 3);
    for (int i = 0; i < 9; i++) add(1, 0, 0, (i % 5) == 4, (i % 5) < 3, 1, 1, 0, 5);
    // ratio 1 offered on the boundary cycle
    add(1, 1, 1, 1, 0, 1, 1, 0, 5);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 1, 1, 1, 0, 1);
    // zero ratio while running
    add(1, 1, 0, 1, 1, 1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 1, 1, 1, 1);
    add(1, 0, 0, 1, 1, 1, 1, 0, 1);

    do_reset();
    check_outs("reset", 0, 0, 0, 1, 0, DEF_DIV);
    for (int i = 0; i < vecs.size(); i++) begin
      check_outs($sformatf("vec%0d", i), vecs[i].t, vecs[i].dv, vecs[i].b,
                 vecs[i].r, vecs[i].e, vecs[i].a);
      apply(vecs[i].en, vecs[i].v, vecs[i].d);
    end

    // zero ratio in IDLE, then spacing still 3
    do_reset();
    apply(0, 1, 0);
    chk("idle_zero.err", int'(cfg_err), 1);
    chk("idle_zero.active", int'(active_div), 3);
    apply(0, 0, 0);
    chk("idle_zero.err_clear", int'(cfg_err), 0);
    apply(1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk("idle_zero.spacing", int'(tick), (k % 3) == 2);
      apply(1, 0, 0);
    end

    // stop at cnt 0 with N=4
    do_reset();
    apply(0, 1, 4);
    chk("stop.active", int'(active_div), 4);
    apply(1, 0, 0);
    chk("stop.c0_busy", int'(busy), 1);
    chk("stop.c0_div", int'(div_out), 1);
    apply(0, 0, 0);
    chk("stop.c1_busy", int'(busy), 1);
    chk("stop.c1_tick", int'(tick), 0);
    apply(0, 0, 0);
    chk("stop.c2_div", int'(div_out), 0);
    apply(0, 0, 0);
    chk("stop.c3_tick", int'(tick), 1);
    chk("stop.c3_busy", int'(busy), 1);
    apply(0, 0, 0);
    chk("stop.idle_busy", int'(busy), 0);
    chk("stop.idle_tick", int'(tick), 0);
    chk("stop.idle_div", int'(div_out), 0);

    // restart, drop then re-raise enable during DRAIN
    apply(1, 0, 0);
    apply(0, 0, 0);
    chk("drain.c1_busy", int'(busy), 1);
    apply(1, 0, 0);
    apply(1, 0, 0);
    chk("drain.c3_tick", int'(tick), 1);
    apply(1, 0, 0);
    chk("drain.c0_busy", int'(busy), 1);
    chk("drain.c0_div", int'(div_out), 1);
    apply(1, 0, 0);
    apply(1, 0, 0);
    apply(1, 0, 0);
    chk("drain.next_tick", int'(tick), 1);

    // async reset mid-period with a pending ratio
    apply(1, 0, 0);
    apply(1, 1, 7);
    chk("areset.pend_ready", int'(cfg_ready), 0);
    apply(1, 0, 0);
    chk("areset.c2_busy", int'(busy), 1);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check_outs("areset.async", 0, 0, 0, 1, 0, DEF_DIV);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_outs("areset.after", 0, 0, 0, 1, 0, DEF_DIV);

    // randomized run against the reference model
    do_reset();
    model_reset();
    begin
      int en, v, d;
      en = 1;
      for (int c = 0; c < 3000; c++) begin
        check_outs("rand",
                   m_busy && (m_pos == m_n - 1),
                   m_busy && (2 * m_pos < m_n),
                   m_busy,
                   pq.size() == 0,
                   m_err,
                   m_n);
        if ($urandom_range(0, 9) == 0) en = !en;
        v = ($urandom_range(0, 3) == 0);
        d = $urandom_range(0, 6);
        model_step(en, v, d);
        apply(en[0], v[0], d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
